// File: rtl/pem_ld_regf_packer.sv
// Load-side packer: gathers SUBW_NB AXI read beats into one regfile write word
// and paces regfile writes so that PEA/PEP keep free write slots.
module pem_ld_regf_packer #(
  parameter int unsigned AXI4_W       = 512,
  parameter int unsigned MOD_Q_W      = 64,
  parameter int unsigned COEF_PER_AXI = 8,
  parameter int unsigned REGF_COEF_NB = 32,
  parameter int unsigned REGF_PERIOD  = 4,
  parameter int unsigned REGID_W      = 6,
  parameter int unsigned WORD_NB_W    = 10
) (
  input  logic                            clk,
  input  logic                            s_rst,
  input  logic                            cmd_vld,
  output logic                            cmd_rdy,
  input  logic [REGID_W-1:0]              cmd_rid,
  input  logic [WORD_NB_W-1:0]            cmd_word_nb,
  input  logic [AXI4_W-1:0]               axi_data,
  input  logic                            axi_vld,
  output logic                            axi_rdy,
  output logic                            regf_wr_vld,
  input  logic                            regf_wr_rdy,
  output logic [REGID_W-1:0]              regf_wr_rid,
  output logic [WORD_NB_W-1:0]            regf_wr_word_idx,
  output logic [REGF_COEF_NB*MOD_Q_W-1:0] regf_wr_data,
  output logic                            done
);

  localparam int unsigned SUBW_NB = REGF_COEF_NB / COEF_PER_AXI;
  localparam int unsigned SUBW_W  = COEF_PER_AXI * MOD_Q_W;
  localparam int unsigned BEAT_W  = (SUBW_NB > 1) ? $clog2(SUBW_NB) : 1;
  localparam int unsigned PER_W   = (REGF_PERIOD > 1) ? $clog2(REGF_PERIOD) : 1;

  if (COEF_PER_AXI == 0 || (REGF_COEF_NB % COEF_PER_AXI) != 0) begin : gen_chk_div
    $error("REGF_COEF_NB must be a non-zero multiple of COEF_PER_AXI");
  end
  if (SUBW_W > AXI4_W) begin : gen_chk_axi_w
    $error("COEF_PER_AXI*MOD_Q_W must not exceed AXI4_W");
  end
  if (REGF_PERIOD < 1) begin : gen_chk_period
    $error("REGF_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e               state_q, state_d;
  logic [WORD_NB_W-1:0] word_nb_q;
  logic [BEAT_W-1:0]    beat_q;
  logic [PER_W-1:0]     period_q;
  logic                 buf_full_q;

  logic cmd_hs;
  logic axi_hs;
  logic wr_hs;
  logic last_word;

  assign regf_wr_vld = buf_full_q & (period_q == '0);
  assign cmd_hs      = cmd_vld & cmd_rdy;
  assign axi_hs      = axi_vld & axi_rdy;
  assign wr_hs       = regf_wr_vld & regf_wr_rdy;
  assign last_word   = (regf_wr_word_idx == word_nb_q - WORD_NB_W'(1));

  // Next-state and handshake outputs; reset masks the ready signals in the reset cycle.
  always_comb begin
    state_d = state_q;
    cmd_rdy = 1'b0;
    axi_rdy = 1'b0;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        cmd_rdy = !s_rst;
        if (cmd_vld && !s_rst) begin
          state_d = (cmd_word_nb == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        axi_rdy = !buf_full_q && !s_rst;
        if (wr_hs && last_word) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: beat gathering, write pacing and command bookkeeping.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      word_nb_q        <= '0;
      beat_q           <= '0;
      period_q         <= '0;
      buf_full_q       <= 1'b0;
      regf_wr_rid      <= '0;
      regf_wr_word_idx <= '0;
      regf_wr_data     <= '0;
    end else begin
      if (axi_hs) begin
        // Upper AXI bits beyond the coefficient slots are dropped.
        regf_wr_data[beat_q*SUBW_W +: SUBW_W] <= axi_data[SUBW_W-1:0];
        if (beat_q == BEAT_W'(SUBW_NB - 1)) begin
          beat_q     <= '0;
          buf_full_q <= 1'b1;
        end else begin
          beat_q <= beat_q + BEAT_W'(1);
        end
      end

      if (wr_hs) begin
        buf_full_q       <= 1'b0;
        regf_wr_word_idx <= regf_wr_word_idx + WORD_NB_W'(1);
        period_q         <= PER_W'(REGF_PERIOD - 1);
      end else if (period_q != '0) begin
        period_q <= period_q - PER_W'(1);
      end

      // A new command starts from a clean slate (only reachable in idle).
      if (cmd_hs) begin
        regf_wr_rid      <= cmd_rid;
        word_nb_q        <= cmd_word_nb;
        regf_wr_word_idx <= '0;
        beat_q           <= '0;
        period_q         <= '0;
        buf_full_q       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pem_ld_regf_packer.sv
// Directed bench for pem_ld_regf_packer with a queue-based write scoreboard.
module tb_pem_ld_regf_packer;

  localparam int AXI4_W = 512;
  localparam int QW     = 64;
  localparam int CPA    = 8;
  localparam int NCOEF  = 32;
  localparam int DW     = NCOEF * QW;

  typedef struct {
    logic [5:0]    rid;
    logic [9:0]    idx;
    logic [DW-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              s_rst = 1'b0;
  logic              cmd_vld = 1'b0;
  logic              cmd_rdy;
  logic [5:0]        cmd_rid = '0;
  logic [9:0]        cmd_word_nb = '0;
  logic [AXI4_W-1:0] axi_data = '0;
  logic              axi_vld = 1'b0;
  logic              axi_rdy;
  logic              regf_wr_vld;
  logic              regf_wr_rdy = 1'b0;
  logic [5:0]        regf_wr_rid;
  logic [9:0]        regf_wr_word_idx;
  logic [DW-1:0]     regf_wr_data;
  logic              done;

  pem_ld_regf_packer dut (
    .clk              (clk),
    .s_rst            (s_rst),
    .cmd_vld          (cmd_vld),
    .cmd_rdy          (cmd_rdy),
    .cmd_rid          (cmd_rid),
    .cmd_word_nb      (cmd_word_nb),
    .axi_data         (axi_data),
    .axi_vld          (axi_vld),
    .axi_rdy          (axi_rdy),
    .regf_wr_vld      (regf_wr_vld),
    .regf_wr_rdy      (regf_wr_rdy),
    .regf_wr_rid      (regf_wr_rid),
    .regf_wr_word_idx (regf_wr_word_idx),
    .regf_wr_data     (regf_wr_data),
    .done             (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_cnt  = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_wr_cyc = -1;
  int axi_acc = 0;
  bit axi_en = 1'b1;
  bit wr_rdy_en = 1'b1;

  logic [AXI4_W-1:0] axi_q[$];
  exp_t              exp_q[$];

  task automatic chk(input logic [63:0] obs, input logic [63:0] expv, input string tag);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Queue the four beats of one regfile word; coefficient value = base + 8*b + k.
  task automatic push_word(input logic [5:0] rid, input logic [9:0] idx, input logic [63:0] base);
    logic [AXI4_W-1:0] beat;
    exp_t e;
    e.rid  = rid;
    e.idx  = idx;
    e.data = '0;
    for (int b = 0; b < NCOEF / CPA; b++) begin
      beat = '0;
      for (int k = 0; k < CPA; k++) begin
        beat[k*QW +: QW]               = base + 64'(8 * b + k);
        e.data[(b*CPA + k)*QW +: QW]   = base + 64'(8 * b + k);
      end
      axi_q.push_back(beat);
    end
    exp_q.push_back(e);
  endtask

  // Move to the next cycle (inputs may then be changed before mon()).
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Drive source/sink inputs, let logic settle, then score handshakes due at the next edge.
  task automatic mon();
    exp_t e;
    axi_vld     = axi_en && (axi_q.size() > 0);
    axi_data    = (axi_q.size() > 0) ? axi_q[0] : '0;
    regf_wr_rdy = wr_rdy_en;
    #1;
    if (regf_wr_vld && regf_wr_rdy) begin
      if (exp_q.size() == 0) begin
        chk(64'd1, 64'd0, "wr_unexpected");
      end else begin
        e = exp_q.pop_front();
        chk(64'(regf_wr_rid), 64'(e.rid), "wr_rid");
        chk(64'(regf_wr_word_idx), 64'(e.idx), "wr_idx");
        for (int n = 0; n < NCOEF; n++) begin
          chk(regf_wr_data[n*QW +: QW], e.data[n*QW +: QW], $sformatf("wr_data_slot%0d", n));
        end
      end
      if (last_wr_cyc >= 0) chk(64'(cyc - last_wr_cyc >= 4), 64'd1, "wr_spacing");
      last_wr_cyc = cyc;
      wr_cnt++;
    end
    if (regf_wr_vld) chk(64'(axi_rdy), 64'd0, "axi_rdy_while_full");
    if (axi_vld && axi_rdy) begin
      void'(axi_q.pop_front());
      axi_acc++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic cycle();
    step();
    mon();
  endtask

  task automatic issue(input logic [5:0] rid, input logic [9:0] nb);
    int n = 0;
    step();
    cmd_vld = 1'b1;
    cmd_rid = rid;
    cmd_word_nb = nb;
    mon();
    while (!cmd_rdy && n < 50) begin
      cycle();
      n++;
    end
    chk(64'(cmd_rdy), 64'd1, "cmd_accept");
    last_wr_cyc = -1;
    step();
    cmd_vld = 1'b0;
    mon();
  endtask

  // Run until done is seen; leaves the bench in the done cycle.
  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      cycle();
      n++;
    end
    chk(64'(done), 64'd1, "done_seen");
  endtask

  int wr0;
  int dn0;

  initial begin
    // Reset
    step(); s_rst = 1'b1; mon();
    chk(64'(cmd_rdy), 64'd0, "rst_cmd_rdy_in_reset");
    step(); s_rst = 1'b0; mon();
    chk(64'(cmd_rdy), 64'd1, "rst_cmd_rdy");
    chk(64'(axi_rdy), 64'd0, "rst_axi_rdy");
    chk(64'(regf_wr_vld), 64'd0, "rst_wr_vld");
    chk(64'(done), 64'd0, "rst_done");
    chk(64'(regf_wr_rid), 64'd0, "rst_rid");
    chk(64'(regf_wr_word_idx), 64'd0, "rst_idx");
    chk(regf_wr_data[63:0], 64'd0, "rst_data");

    // Single word: slot n holds n
    wr0 = wr_cnt;
    push_word(6'd5, 10'd0, 64'd0);
    issue(6'd5, 10'd1);
    wait_done(40);
    chk(64'(wr_cnt - wr0), 64'd1, "single_wr_count");
    chk(64'(done_cyc - last_wr_cyc), 64'd1, "single_done_latency");
    cycle();
    chk(64'(done), 64'd0, "single_done_pulse_len");
    chk(64'(cmd_rdy), 64'd1, "single_cmd_rdy_idle");

    // Throttle: three words, everything streaming
    wr0 = wr_cnt;
    for (int w = 0; w < 3; w++) push_word(6'd9, 10'(w), 64'h1000 + 64'(w * 32));
    issue(6'd9, 10'd3);
    chk(64'(cmd_rdy), 64'd0, "thr_cmd_rdy_load");
    wait_done(200);
    chk(64'(wr_cnt - wr0), 64'd3, "thr_wr_count");
    chk(64'(exp_q.size()), 64'd0, "thr_exp_empty");

    // Backpressure: regfile not ready for 10 cycles
    wr0 = wr_cnt;
    wr_rdy_en = 1'b0;
    push_word(6'd12, 10'd0, 64'h2000);
    push_word(6'd12, 10'd1, 64'h3000);
    issue(6'd12, 10'd2);
    for (int n = 0; n < 40 && !regf_wr_vld; n++) cycle();
    chk(64'(regf_wr_vld), 64'd1, "bp_vld_rise");
    for (int n = 0; n < 10; n++) begin
      cycle();
      chk(64'(regf_wr_vld), 64'd1, "bp_vld_hold");
      chk(64'(regf_wr_rid), 64'd12, "bp_rid_hold");
      chk(64'(regf_wr_word_idx), 64'd0, "bp_idx_hold");
      chk(regf_wr_data[63:0], exp_q[0].data[63:0], "bp_data0_hold");
      chk(regf_wr_data[DW-1 -: 64], exp_q[0].data[DW-1 -: 64], "bp_data31_hold");
      chk(64'(axi_rdy), 64'd0, "bp_axi_rdy_stall");
    end
    wr_rdy_en = 1'b1;
    wait_done(200);
    chk(64'(wr_cnt - wr0), 64'd2, "bp_wr_count");

    // Zero length
    wr0 = wr_cnt;
    issue(6'd3, 10'd0);
    chk(64'(done), 64'd1, "zero_done");
    chk(64'(cmd_rdy), 64'd0, "zero_cmd_rdy_done");
    chk(64'(axi_rdy), 64'd0, "zero_axi_rdy");
    cycle();
    chk(64'(done), 64'd0, "zero_done_len");
    chk(64'(cmd_rdy), 64'd1, "zero_cmd_rdy_back");
    chk(64'(wr_cnt - wr0), 64'd0, "zero_no_write");

    // Reset mid-command after two beats
    push_word(6'd20, 10'd0, 64'h100);
    issue(6'd20, 10'd1);
    wr0 = axi_acc;
    for (int n = 0; n < 20 && (axi_acc - wr0) < 2; n++) cycle();
    chk(64'(axi_acc - wr0), 64'd2, "mid_two_beats");
    dn0 = done_cnt;
    step();
    s_rst = 1'b1;
    axi_q.delete();
    exp_q.delete();
    mon();
    step(); s_rst = 1'b0; mon();
    chk(64'(cmd_rdy), 64'd1, "mid_rst_cmd_rdy");
    chk(64'(axi_rdy), 64'd0, "mid_rst_axi_rdy");
    chk(64'(regf_wr_vld), 64'd0, "mid_rst_vld");
    chk(64'(regf_wr_rid), 64'd0, "mid_rst_rid");
    chk(regf_wr_data[63:0], 64'd0, "mid_rst_data");
    cycle();
    chk(64'(done_cnt - dn0), 64'd0, "mid_rst_no_done");
    wr0 = wr_cnt;
    push_word(6'd21, 10'd0, 64'h4000);
    issue(6'd21, 10'd1);
    wait_done(40);
    chk(64'(wr_cnt - wr0), 64'd1, "mid_new_wr_count");

    // Back-to-back: second command waits through DONE
    cycle();
    wr0 = wr_cnt;
    push_word(6'd30, 10'd0, 64'h5000);
    push_word(6'd31, 10'd0, 64'h6000);
    issue(6'd30, 10'd1);
    step();
    cmd_vld = 1'b1;
    cmd_rid = 6'd31;
    cmd_word_nb = 10'd1;
    mon();
    for (int n = 0; n < 40 && !done; n++) cycle();
    chk(64'(done), 64'd1, "b2b_first_done");
    chk(64'(cmd_rdy), 64'd0, "b2b_cmd_rdy_in_done");
    cycle();
    chk(64'(cmd_rdy), 64'd1, "b2b_accept_idle");
    step(); cmd_vld = 1'b0; mon();
    wait_done(40);
    chk(64'(wr_cnt - wr0), 64'd2, "b2b_wr_count");
    chk(64'(exp_q.size()), 64'd0, "b2b_exp_empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
